// File: rtl/en_stack_pkg.sv
// Shared definitions for the per-lane SIMD enable stack.
// Holds the 3-bit op encoding used by the instruction decoder and by simd_en_stack.
package en_stack_pkg;

    typedef enum logic [2:0] {
        EN_NOP    = 3'd0,
        EN_ALLEN  = 3'd1,
        EN_PUSHEN = 3'd2,
        EN_POPEN  = 3'd3,
        EN_CLRIF  = 3'd4,
        EN_ELSE   = 3'd5,
        EN_PUSHIF = 3'd6,
        EN_RSVD   = 3'd7   // decodes as NOP, raises no flag
    } op_t;

endpackage

// File: rtl/simd_en_stack_if.sv
// Op/status bundle between the stage-2 control logic and simd_en_stack.
// master (pipeline control): drives hold, op_valid, op_i, cond_i, clr_err;
//                            observes en_o, any_en_o, depth_o, ovf_o, unf_o.
// slave  (simd_en_stack):    the reverse.
interface simd_en_stack_if
    import en_stack_pkg::*;
#(
    parameter int unsigned NLANES = 8,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned DW = $clog2(DEPTH);

    logic              hold;
    logic              op_valid;
    op_t               op_i;
    logic [NLANES-1:0] cond_i;
    logic              clr_err;
    logic [NLANES-1:0] en_o;
    logic              any_en_o;
    logic [DW-1:0]     depth_o;
    logic              ovf_o;
    logic              unf_o;

    modport master (
        output hold, op_valid, op_i, cond_i, clr_err,
        input  en_o, any_en_o, depth_o, ovf_o, unf_o
    );

    modport slave (
        input  hold, op_valid, op_i, cond_i, clr_err,
        output en_o, any_en_o, depth_o, ovf_o, unf_o
    );

endinterface

// File: rtl/en_lane_stack.sv
// One lane's enable stack: DEPTH bits, bit 0 is the top of stack.
// Ports:
//   clk, reset   clock and synchronous active-high reset (all entries to 1)
//   push_i       shift down, top kept
//   pop_i        shift up, bottom entry duplicated
//   allen_i      top <= 1
//   clrif_i      top <= top & ~cond_i (may combine with push_i for PUSHIF)
//   else_i       top <= ~top & below_i
//   cond_i       this lane's "condition false" bit
//   below_i      entry under the top, or 1 when the stack is at its base
//   top_o        registered top entry
//   second_o     registered entry 1, used by the parent to form below_i
//   top_nxt_o    next-state top entry
// Strobes are already gated for hold and overflow/underflow by the parent.
module en_lane_stack #(
    parameter int unsigned DEPTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  logic allen_i,
    input  logic clrif_i,
    input  logic else_i,
    input  logic cond_i,
    input  logic below_i,
    output logic top_o,
    output logic second_o,
    output logic top_nxt_o
);

    logic [DEPTH-1:0] stk_q, stk_d;

    always_comb begin
        stk_d = stk_q;
        if (push_i) begin
            stk_d[DEPTH-1:1] = stk_q[DEPTH-2:0];
        end
        if (pop_i) begin
            stk_d = {stk_q[DEPTH-1], stk_q[DEPTH-1:1]};
        end
        // Top writes use the old top; a push leaves the top in place so
        // PUSHIF composes from push_i and clrif_i together.
        if (allen_i) begin
            stk_d[0] = 1'b1;
        end
        if (clrif_i) begin
            stk_d[0] = stk_q[0] & ~cond_i;
        end
        if (else_i) begin
            stk_d[0] = ~stk_q[0] & below_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stk_q <= '1;
        end else begin
            stk_q <= stk_d;
        end
    end

    assign top_o     = stk_q[0];
    assign second_o  = stk_q[1];
    assign top_nxt_o = stk_d[0];

endmodule

// File: rtl/simd_en_stack.sv
// Per-lane predication enable stack beside pipeline stage 2.
// The top-of-stack mask gates writeback, store and trap per lane.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset; dominates everything
//   bus    simd_en_stack_if slave: hold, op_valid, op_i, cond_i, clr_err in;
//          en_o, any_en_o, depth_o, ovf_o, unf_o out (all registered)
// Lanes share depth, flags and op; each lane holds its own stack.
module simd_en_stack
    import en_stack_pkg::*;
#(
    parameter int unsigned NLANES = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic           clk,
    input  logic           reset,
    simd_en_stack_if.slave bus
);

    localparam int unsigned   DW       = $clog2(DEPTH);
    localparam logic [DW-1:0] DepthMax = DW'(DEPTH - 1);

    logic [DW-1:0]     depth_q;
    logic              ovf_q, unf_q, any_q;

    logic              accept, full, empty;
    logic              is_push, is_pop, is_pushif, is_clrif;
    logic              push_ok, pop_ok, allen, clrif, nelse;
    logic              ovf_ev, unf_ev;
    logic [NLANES-1:0] top, second, top_nxt, below;

    always_comb begin
        accept    = bus.op_valid & ~bus.hold;
        full      = (depth_q == DepthMax);
        empty     = (depth_q == '0);
        is_push   = 1'b0;
        is_pop    = 1'b0;
        is_pushif = 1'b0;
        is_clrif  = 1'b0;
        allen     = 1'b0;
        nelse     = 1'b0;
        if (accept) begin
            case (bus.op_i)
                EN_ALLEN:  allen = 1'b1;
                EN_PUSHEN: is_push = 1'b1;
                EN_POPEN:  is_pop = 1'b1;
                EN_CLRIF:  is_clrif = 1'b1;
                EN_ELSE:   nelse = 1'b1;
                EN_PUSHIF: begin
                    is_push   = 1'b1;
                    is_pushif = 1'b1;
                end
                default: ;
            endcase
        end
        push_ok = is_push & ~full;
        ovf_ev  = is_push & full;
        pop_ok  = is_pop & ~empty;
        unf_ev  = is_pop & empty;
        // An overflowing PUSHIF drops its conditional part as well.
        clrif   = is_clrif | (is_pushif & ~full);
        below   = empty ? '1 : second;
    end

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        en_lane_stack #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .push_i    (push_ok),
            .pop_i     (pop_ok),
            .allen_i   (allen),
            .clrif_i   (clrif),
            .else_i    (nelse),
            .cond_i    (bus.cond_i[l]),
            .below_i   (below[l]),
            .top_o     (top[l]),
            .second_o  (second[l]),
            .top_nxt_o (top_nxt[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            any_q   <= 1'b1;
        end else if (!bus.hold) begin
            if (push_ok) begin
                depth_q <= depth_q + DW'(1);
            end else if (pop_ok) begin
                depth_q <= depth_q - DW'(1);
            end
            // A fresh error wins over a same-cycle clear.
            ovf_q <= (ovf_q & ~bus.clr_err) | ovf_ev;
            unf_q <= (unf_q & ~bus.clr_err) | unf_ev;
            any_q <= |top_nxt;
        end
    end

    assign bus.en_o     = top;
    assign bus.any_en_o = any_q;
    assign bus.depth_o  = depth_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.unf_o    = unf_q;

endmodule

// File: tb/tb_simd_en_stack.sv
// Self-checking bench for simd_en_stack (NLANES=4, DEPTH=4).
// A reference model predicts each cycle's outputs into a scoreboard queue; the
// entry is popped and compared once the DUT has clocked that cycle.
module tb_simd_en_stack;
    import en_stack_pkg::*;

    localparam int unsigned NL = 4;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simd_en_stack_if #(.NLANES(NL), .DEPTH(DP)) bus ();

    simd_en_stack #(
        .NLANES (NL),
        .DEPTH  (DP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] en;
        logic       any;
        logic [1:0] dep;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic [3:0] m_stk[DP];
    int         m_depth;
    logic       m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic hld, input logic vld, input op_t op,
                              input logic [3:0] cond, input logic clr);
        logic new_ovf, new_unf;
        logic [3:0] blw;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (rst) begin
            for (int i = 0; i < DP; i++) m_stk[i] = 4'hF;
            m_depth = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (!hld) begin
            if (vld) begin
                case (op)
                    EN_ALLEN: m_stk[0] = 4'hF;
                    EN_PUSHEN, EN_PUSHIF: begin
                        if (m_depth == DP - 1) begin
                            new_ovf = 1'b1;
                        end else begin
                            for (int i = DP - 1; i > 0; i--) m_stk[i] = m_stk[i-1];
                            m_depth++;
                            if (op == EN_PUSHIF) m_stk[0] = m_stk[0] & ~cond;
                        end
                    end
                    EN_POPEN: begin
                        if (m_depth == 0) begin
                            new_unf = 1'b1;
                        end else begin
                            for (int i = 0; i < DP - 1; i++) m_stk[i] = m_stk[i+1];
                            m_depth--;
                        end
                    end
                    EN_CLRIF: m_stk[0] = m_stk[0] & ~cond;
                    EN_ELSE: begin
                        blw = (m_depth > 0) ? m_stk[1] : 4'hF;
                        m_stk[0] = ~m_stk[0] & blw;
                    end
                    default: ;
                endcase
            end
            if (clr) begin
                m_ovf = new_ovf;
                m_unf = new_unf;
            end else begin
                m_ovf = m_ovf | new_ovf;
                m_unf = m_unf | new_unf;
            end
        end
    endtask

    // Drive one cycle, predict, clock, then compare away from the edge.
    task automatic cyc(input logic rst, input logic hld, input logic vld, input op_t op,
                       input logic [3:0] cond, input logic clr, input string tag);
        exp_t e;
        reset        = rst;
        bus.hold     = hld;
        bus.op_valid = vld;
        bus.op_i     = op;
        bus.cond_i   = cond;
        bus.clr_err  = clr;
        model_step(rst, hld, vld, op, cond, clr);
        e.tag = tag;
        e.en  = m_stk[0];
        e.any = |m_stk[0];
        e.dep = 2'(m_depth);
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_en"},    32'(bus.en_o),     32'(e.en));
            chk({e.tag, "_any"},   32'(bus.any_en_o), 32'(e.any));
            chk({e.tag, "_depth"}, 32'(bus.depth_o),  32'(e.dep));
            chk({e.tag, "_ovf"},   32'(bus.ovf_o),    32'(e.ovf));
            chk({e.tag, "_unf"},   32'(bus.unf_o),    32'(e.unf));
        end
    endtask

    task automatic op1(input op_t op, input logic [3:0] cond, input string tag);
        cyc(1'b0, 1'b0, 1'b1, op, cond, 1'b0, tag);
    endtask

    initial begin
        logic r, h, v, c;
        op_t  o;
        logic [3:0] cd;

        for (int i = 0; i < DP; i++) m_stk[i] = 4'hF;
        m_depth = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset and idle
        cyc(1'b1, 1'b0, 1'b0, EN_NOP, 4'h0, 1'b0, "reset");
        cyc(1'b0, 1'b0, 1'b0, EN_NOP, 4'h0, 1'b0, "idle");
        chk("idle_lit_en", 32'(bus.en_o), 32'hF);

        // Simple if/else/endif
        op1(EN_PUSHIF, 4'b0101, "pushif");
        chk("pushif_lit_en", 32'(bus.en_o), 32'b1010);
        chk("pushif_lit_depth", 32'(bus.depth_o), 32'd1);
        op1(EN_ELSE, 4'h0, "else");
        chk("else_lit_en", 32'(bus.en_o), 32'b0101);
        op1(EN_POPEN, 4'h0, "pop");
        chk("pop_lit_en", 32'(bus.en_o), 32'hF);

        // Nested sequence
        op1(EN_PUSHIF, 4'b0011, "n_pushif1");
        op1(EN_PUSHIF, 4'b0100, "n_pushif2");
        chk("n_pushif2_lit", 32'(bus.en_o), 32'b1000);
        op1(EN_ELSE, 4'h0, "n_else1");
        chk("n_else1_lit", 32'(bus.en_o), 32'b0100);
        op1(EN_POPEN, 4'h0, "n_pop");
        op1(EN_ELSE, 4'h0, "n_else2");
        chk("n_else2_lit", 32'(bus.en_o), 32'b0011);
        op1(EN_CLRIF, 4'b0011, "n_clrif");
        chk("n_clrif_lit_any", 32'(bus.any_en_o), 32'd0);
        op1(EN_ALLEN, 4'h0, "n_allen");
        op1(EN_POPEN, 4'h0, "n_pop_base");

        // Underflow and clear
        op1(EN_POPEN, 4'h0, "unf_pop");
        chk("unf_lit", 32'(bus.unf_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, EN_NOP, 4'h0, 1'b1, "unf_clr");
        cyc(1'b0, 1'b0, 1'b1, EN_POPEN, 4'h0, 1'b1, "unf_clr_pop");
        cyc(1'b0, 1'b0, 1'b1, EN_RSVD, 4'hF, 1'b1, "rsvd_clr");

        // Overflow
        op1(EN_PUSHEN, 4'h0, "ovf_push1");
        op1(EN_PUSHEN, 4'h0, "ovf_push2");
        op1(EN_PUSHEN, 4'h0, "ovf_push3");
        op1(EN_PUSHIF, 4'hF, "ovf_pushif");
        chk("ovf_lit", 32'(bus.ovf_o), 32'd1);
        chk("ovf_lit_en", 32'(bus.en_o), 32'hF);

        // Hold and reset priority
        cyc(1'b0, 1'b1, 1'b1, EN_POPEN, 4'h0, 1'b1, "hold_pop_clr");
        op1(EN_POPEN, 4'h0, "pop_to2");
        op1(EN_CLRIF, 4'b1001, "clrif_d2");
        cyc(1'b0, 1'b1, 1'b1, EN_PUSHEN, 4'h0, 1'b0, "hold_push");
        cyc(1'b1, 1'b1, 1'b1, EN_PUSHIF, 4'hF, 1'b1, "reset_prio");
        chk("reset_prio_lit_depth", 32'(bus.depth_o), 32'd0);

        // Random mix against the model
        for (int n = 0; n < 200; n++) begin
            r  = ($urandom_range(0, 29) == 0);
            h  = ($urandom_range(0, 5) == 0);
            v  = ($urandom_range(0, 4) != 0);
            o  = op_t'(3'($urandom_range(0, 7)));
            cd = 4'($urandom);
            c  = ($urandom_range(0, 7) == 0);
            cyc(r, h, v, o, cd, c, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
